// File: rtl/light_seq_pkg.sv
// Shared definitions for the light sequencer: FSM encoding and LFSR tap masks.
package light_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_PICK = 2'd2,
    ST_ON   = 2'd3
  } state_t;

  // Maximal-length Fibonacci masks, bit n-1 set for polynomial term x^n.
  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_9  = 64'h0000_0000_0000_0110;
  localparam logic [63:0] TAPS_10 = 64'h0000_0000_0000_0240;
  localparam logic [63:0] TAPS_11 = 64'h0000_0000_0000_0500;
  localparam logic [63:0] TAPS_12 = 64'h0000_0000_0000_0E08;
  localparam logic [63:0] TAPS_13 = 64'h0000_0000_0000_1C80;
  localparam logic [63:0] TAPS_14 = 64'h0000_0000_0000_3802;
  localparam logic [63:0] TAPS_15 = 64'h0000_0000_0000_6000;
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_20 = 64'h0000_0000_0009_0000;
  localparam logic [63:0] TAPS_24 = 64'h0000_0000_00E1_0000;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;

  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return TAPS_8;
      9:       return TAPS_9;
      10:      return TAPS_10;
      11:      return TAPS_11;
      12:      return TAPS_12;
      13:      return TAPS_13;
      14:      return TAPS_14;
      15:      return TAPS_15;
      20:      return TAPS_20;
      24:      return TAPS_24;
      32:      return TAPS_32;
      default: return TAPS_16;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Left-shifting Fibonacci LFSR; a zero seed is forced to 1 so the register never locks up.
module lfsr_gen #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= WIDTH'(1);
    else if (load)
      value <= (seed == '0) ? WIDTH'(1) : seed;
    else
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
  end

endmodule

// File: rtl/light_sequencer.sv
// Whack-a-mole sequencer: gap, random pick, timed light with hit/miss scoring.
// Define LIGHT_SEQ_NO_REPEAT_EN to forbid lighting the same LED twice in a row.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter  int NUM_LIGHTS = 9,
  parameter  int TIME_W     = 28,
  parameter  int LFSR_W     = 16,
  localparam int IDX_W      = $clog2(NUM_LIGHTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_seed,
  input  logic [LFSR_W-1:0]     seed,
  input  logic [TIME_W-1:0]     light_on,
  input  logic [TIME_W-1:0]     light_between,
  input  logic [NUM_LIGHTS-1:0] hit,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  hit_pulse,
  output logic                  miss_pulse
);

  localparam logic [63:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [IDX_W:0]    NL       = (IDX_W+1)'(NUM_LIGHTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LIGHTS - 1);

  // A programmed time of 0 behaves as 1 cycle, so the counter preload saturates at 0.
  function automatic logic [TIME_W-1:0] load_val(input logic [TIME_W-1:0] t);
    return (t == '0) ? '0 : t - TIME_W'(1);
  endfunction

  state_t                  state, state_nxt;
  logic [TIME_W-1:0]       cnt, cnt_nxt;
  logic [LFSR_W-1:0]       lfsr;
  logic [IDX_W:0]          raw, red;
  logic [IDX_W-1:0]        idx_pick, idx_nxt;
  logic [NUM_LIGHTS-1:0]   lights_nxt;
  logic                    hit_now, miss_now;

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load_seed),
    .seed  (seed),
    .value (lfsr)
  );

`ifdef LIGHT_SEQ_NO_REPEAT_EN
  logic [IDX_W-1:0] last_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_idx <= LAST_IDX;
    else if (enable && state == ST_PICK)
      last_idx <= idx_pick;
  end
`endif

  // Fold the raw LFSR slice into 0..NUM_LIGHTS-1 with a single conditional subtract.
  always_comb begin
    raw      = {1'b0, lfsr[IDX_W-1:0]};
    red      = (raw >= NL) ? raw - NL : raw;
    idx_pick = red[IDX_W-1:0];
`ifdef LIGHT_SEQ_NO_REPEAT_EN
    if (idx_pick == last_idx)
      idx_pick = (idx_pick == LAST_IDX) ? '0 : idx_pick + IDX_W'(1);
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = active_idx;
    hit_now   = 1'b0;
    miss_now  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_GAP;
          cnt_nxt   = load_val(light_between);
        end
        ST_GAP: begin
          if (cnt == '0) state_nxt = ST_PICK;
          else           cnt_nxt   = cnt - TIME_W'(1);
        end
        ST_PICK: begin
          idx_nxt   = idx_pick;
          cnt_nxt   = load_val(light_on);
          state_nxt = ST_ON;
        end
        ST_ON: begin
          // A hit in the expiry cycle still scores: hit is checked first.
          if (hit[active_idx]) begin
            hit_now   = 1'b1;
            state_nxt = ST_GAP;
            cnt_nxt   = load_val(light_between);
          end else if (cnt == '0) begin
            miss_now  = 1'b1;
            state_nxt = ST_GAP;
            cnt_nxt   = load_val(light_between);
          end else begin
            cnt_nxt   = cnt - TIME_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    lights_nxt = (state_nxt == ST_ON) ? (NUM_LIGHTS'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      active_idx <= '0;
      lights     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_idx <= idx_nxt;
      lights     <= lights_nxt;
      hit_pulse  <= hit_now;
      miss_pulse <= miss_now;
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: per-cycle expectations queued, then checked as cycles elapse.
module tb_light_sequencer;

  localparam int NL = 9;
  localparam int TW = 28;
  localparam int LW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load_seed;
  logic [LW-1:0] seed;
  logic [TW-1:0] light_on;
  logic [TW-1:0] light_between;
  logic [NL-1:0] hit;
  logic [NL-1:0] lights;
  logic [IW-1:0] active_idx;
  logic          hit_pulse;
  logic          miss_pulse;

  light_sequencer #(
    .NUM_LIGHTS (NL),
    .TIME_W     (TW),
    .LFSR_W     (LW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .load_seed     (load_seed),
    .seed          (seed),
    .light_on      (light_on),
    .light_between (light_between),
    .hit           (hit),
    .lights        (lights),
    .active_idx    (active_idx),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lit;
    logic hp;
    logic mp;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          prev_lit;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] last_m;
  logic          pend_hp, pend_mp;

  // Reference LFSR for x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  logic [LW-1:0] m, m_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m      <= 16'd1;
      m_prev <= 16'd1;
    end else begin
      m_prev <= m;
      if (load_seed) m <= (seed == 16'd0) ? 16'd1 : seed;
      else           m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
  end

  task automatic push_period(input int g, input int l, input int hit_at);
    for (int i = 0; i < g; i++)
      q.push_back(exp_t'({1'b0, (i == 0) ? pend_hp : 1'b0, (i == 0) ? pend_mp : 1'b0}));
    q.push_back(exp_t'(3'b000));
    for (int i = 0; i < ((hit_at != 0) ? hit_at : l); i++)
      q.push_back(exp_t'(3'b100));
    pend_hp = (hit_at != 0);
    pend_mp = (hit_at == 0);
  endtask

  task automatic push_flush();
    q.push_back(exp_t'({1'b0, pend_hp, pend_mp}));
    pend_hp = 1'b0;
    pend_mp = 1'b0;
  endtask

  // Advance one cycle, pop the expectation and derive the expected lit index.
  task automatic tick(output exp_t e, output logic [NL-1:0] el);
    logic [IW-1:0] raw, idx;
    @(posedge clk);
    #1;
    e = (q.size() != 0) ? q.pop_front() : exp_t'(3'b000);
    if (e.lit && !prev_lit) begin
      raw = m_prev[IW-1:0];
      idx = (raw >= 4'd9) ? raw - 4'd9 : raw;
`ifdef LIGHT_SEQ_NO_REPEAT_EN
      if (idx == last_m) idx = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
      last_m = idx;
`endif
      cur_idx = idx;
    end
    prev_lit = e.lit;
    el = e.lit ? (9'd1 << cur_idx) : 9'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; load_seed = 1'b0; hit = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    prev_lit = 1'b0; last_m = 4'd8; pend_hp = 1'b0; pend_mp = 1'b0; cur_idx = '0;
  endtask

  task automatic test_reset();
    exp_t e; logic [NL-1:0] el;
    reset = 1'b0; enable = 1'b1; load_seed = 1'b0; seed = '0; hit = '0;
    light_on = 28'd4; light_between = 28'd3;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({lights, active_idx, hit_pulse, miss_pulse} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: lights=%b idx=%0d hit=%b miss=%b expected all zero", lights, active_idx, hit_pulse, miss_pulse);
    end
    enable = 1'b0;
    apply_reset();
    q.push_back(exp_t'(3'b000)); q.push_back(exp_t'(3'b000)); q.push_back(exp_t'(3'b000));
    for (int k = 1; k <= 3; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, active_idx, hit_pulse, miss_pulse} !== {el, 4'd0, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: lights=%b idx=%0d hit=%b miss=%b expected lights=%b idx=0 hit=0 miss=0", k, lights, active_idx, hit_pulse, miss_pulse, el);
      end
    end
  endtask

  task automatic test_miss();
    exp_t e; logic [NL-1:0] el;
    apply_reset();
    light_between = 28'd3; light_on = 28'd4; enable = 1'b1;
    push_period(3, 4, 0); push_period(3, 4, 0); push_period(3, 4, 0); push_flush();
    for (int k = 1; k <= 25; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL miss_run cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      if (e.lit) begin
        n_cmp++;
        if (active_idx !== cur_idx) begin
          n_bad++;
          $display("FAIL miss_idx cycle %0d: active_idx=%0d expected %0d", k, active_idx, cur_idx);
        end
      end
    end
  endtask

  task automatic test_hit();
    exp_t e; logic [NL-1:0] el; int litn;
    apply_reset();
    light_between = 28'd3; light_on = 28'd4; enable = 1'b1; litn = 0;
    push_period(3, 4, 2); push_period(3, 4, 0); push_flush();
    for (int k = 1; k <= 15; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL hit_run cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      if (e.lit) begin
        litn++;
        n_cmp++;
        if (active_idx !== cur_idx) begin
          n_bad++;
          $display("FAIL hit_idx cycle %0d: active_idx=%0d expected %0d", k, active_idx, cur_idx);
        end
      end
      hit = (e.lit && litn == 2) ? el : '0;
    end
  endtask

  task automatic test_wrong_hit();
    exp_t e; logic [NL-1:0] el;
    apply_reset();
    light_between = 28'd3; light_on = 28'd4; enable = 1'b1; hit = '1;
    push_period(3, 4, 0); push_period(3, 4, 0); push_flush();
    for (int k = 1; k <= 17; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL wrong_hit cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      hit = e.lit ? ~el : '1;
    end
    hit = '0;
  endtask

  task automatic test_zero_times();
    exp_t e; logic [NL-1:0] el; int litn;
    apply_reset();
    light_between = 28'd0; light_on = 28'd0; enable = 1'b1; litn = 0;
    push_period(1, 1, 0); push_period(1, 1, 0); push_period(1, 1, 0);
    push_period(1, 1, 1); push_period(1, 1, 0); push_flush();
    for (int k = 1; k <= 16; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL zero_time cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      if (e.lit) litn++;
      hit = (e.lit && litn == 4) ? el : '0;
    end
  endtask

  task automatic test_seed_coverage();
    exp_t e; logic [NL-1:0] el; int seen[NL]; logic [IW-1:0] prev_obs; logic have_prev;
    apply_reset();
    for (int i = 0; i < NL; i++) seen[i] = 0;
    have_prev = 1'b0; prev_obs = '0;
    load_seed = 1'b1; seed = 16'hACE1;
    q.push_back(exp_t'(3'b000));
    tick(e, el);
    load_seed = 1'b0; light_on = 28'd1; light_between = 28'd1; enable = 1'b1;
    for (int p = 0; p < 1000; p++) push_period(1, 1, 0);
    push_flush();
    for (int k = 1; k <= 3001; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL seed_run cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      if (e.lit) begin
        n_cmp++;
        if (active_idx !== cur_idx) begin
          n_bad++;
          $display("FAIL seed_idx cycle %0d: active_idx=%0d expected %0d", k, active_idx, cur_idx);
        end
        if (active_idx < 4'(NL)) seen[active_idx]++;
`ifdef LIGHT_SEQ_NO_REPEAT_EN
        if (have_prev) begin
          n_cmp++;
          if (active_idx === prev_obs) begin
            n_bad++;
            $display("FAIL no_repeat cycle %0d: active_idx=%0d equals previous %0d", k, active_idx, prev_obs);
          end
        end
`endif
        prev_obs = active_idx; have_prev = 1'b1;
      end
    end
    for (int i = 0; i < NL; i++) begin
      n_cmp++;
      if (seen[i] == 0) begin
        n_bad++;
        $display("FAIL coverage idx %0d: seen %0d times, expected at least 1", i, seen[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e; logic [NL-1:0] el;
    apply_reset();
    light_between = 28'd3; light_on = 28'd4; enable = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(exp_t'(3'b000));
    for (int i = 0; i < 4; i++) q.push_back(exp_t'(3'b100));
    for (int i = 0; i < 3; i++) q.push_back(exp_t'(3'b000));
    push_period(3, 4, 0); push_flush();
    for (int k = 1; k <= 20; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL enable_drop cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
      if (k == 8)  enable = 1'b0;
      if (k == 11) enable = 1'b1;
    end
  endtask

  task automatic reset_pulse_check(input string tag);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({lights, active_idx, hit_pulse, miss_pulse} !== '0) begin
      n_bad++;
      $display("FAIL %s: lights=%b idx=%0d hit=%b miss=%b expected all zero", tag, lights, active_idx, hit_pulse, miss_pulse);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    prev_lit = 1'b0; last_m = 4'd8; pend_hp = 1'b0; pend_mp = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    exp_t e; logic [NL-1:0] el;
    apply_reset();
    light_between = 28'd3; light_on = 28'd4; enable = 1'b1;
    push_period(3, 4, 0);
    for (int k = 1; k <= 6; k++) tick(e, el);
    reset_pulse_check("reset_mid_on");
    push_period(3, 4, 0); push_flush(); q.push_back(exp_t'(3'b000));
    for (int k = 1; k <= 10; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL restart_on cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
    end
    reset_pulse_check("reset_mid_gap");
    push_period(3, 4, 0); push_flush();
    for (int k = 1; k <= 9; k++) begin
      tick(e, el);
      n_cmp++;
      if ({lights, hit_pulse, miss_pulse} !== {el, e.hp, e.mp}) begin
        n_bad++;
        $display("FAIL restart_gap cycle %0d: lights=%b hit=%b miss=%b expected lights=%b hit=%b miss=%b", k, lights, hit_pulse, miss_pulse, el, e.hp, e.mp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_wrong_hit();
    test_zero_times();
    test_seed_coverage();
    test_enable_drop();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
